instruction_fetch: RTL and testbench
====================================

// Module: instruction_fetch
// PURPOSE
//  Fetch stage directly upstream of the RV32I decoder. Holds the program counter and issues word reads to
//  instruction memory over a req/gnt/rvalid handshake. Buffers returned words with their PCs in a small FIFO.
//  Presents rawIns/ProgAddr to the decoder with a valid/ready handshake, and flushes on taken-branch redirects.
// PARAMETERS
//  dataW      32  instruction/address width
//  RESET_PC   0   PC loaded on reset; must be word aligned
//  FIFO_DEPTH 2   instruction buffer entries (power of 2, >=2); also caps in-flight + buffered words
// PORTS
//  Clock           in   1      rising-edge clock
//  nReset          in   1      asynchronous active-low reset
//  ImemReq         out  1      read request valid
//  ImemAddr        out  dataW  word-aligned read address ([1:0]=0)
//  ImemGnt         in   1      request accepted this cycle when ImemReq&&ImemGnt
//  ImemRValid      in   1      read data valid; responses in request order, latency >=1 cycle
//  ImemRData       in   dataW  returned instruction word
//  rawIns          out  dataW  instruction to decoder
//  ProgAddr        out  dataW  PC of rawIns
//  InsValid        out  1      rawIns/ProgAddr valid
//  InsReady        in   1      decoder consumes when InsValid&&InsReady
//  Redirect        in   1      taken branch/jump; highest priority
//  BranchAddr      in   dataW  redirect target
//  MisalignFault   out  1      registered one-cycle pulse: redirect target had BranchAddr[1]=1
// BEHAVIOUR
//  Reset: FetchPC=RESET_PC, FIFO empty, InFlight=0, DropCount=0, ImemReq=0, InsValid=0, MisalignFault=0,
//   rawIns=0, ProgAddr=0. Reset mid-transaction discards everything; later ImemRValid ignored until a new grant.
//  ImemReq=1 iff nReset high && !Redirect && (InFlight + Count) < FIFO_DEPTH (comb); guarantees buffer space.
//  ImemAddr=FetchPC. On ImemReq&&ImemGnt: FetchPC+=4 (mod 2^dataW, wraps at 0xFFFFFFFC->0), InFlight++.
//  Each granted request records its PC in a side queue (depth FIFO_DEPTH) popped on each ImemRValid.
//  ImemRValid: InFlight--; if DropCount>0, DropCount-- and data discarded; else push {PC, ImemRData} to FIFO.
//  Same-cycle grant and rvalid: InFlight unchanged.
//  Output: InsValid = FIFO not empty; rawIns/ProgAddr = FIFO head (registered storage, no comb path from ImemRData).
//   Min latency grant->InsValid: memory latency + 1 cycle. Pop on InsValid&&InsReady.
//   Simultaneous push+pop when full allowed only via pop-first accounting (Count stays FIFO_DEPTH-1..).
//  Redirect (synchronous, one cycle): FIFO cleared next cycle; FetchPC={BranchAddr[dataW-1:2],2'b00};
//   DropCount = InFlight_next, where InFlight_next counts this cycle's grants and excludes this cycle's
//   non-dropped rvalid (that word is discarded too).
//   ImemReq forced 0 during the redirect cycle. Fetch resumes next cycle. Dequeue in the redirect cycle is
//   still honoured (decoder owns that instruction).
//  BranchAddr[1]=1: MisalignFault pulses next cycle; target still aligned by clearing [1:0].
//   BranchAddr[0] is always ignored (JALR rule).
//  Back-to-back Redirects: each recomputes DropCount from total outstanding; the last target wins.
//  Invariants: InFlight+Count<=FIFO_DEPTH; DropCount<=InFlight; InsValid never asserted with a stale-epoch word.
//  FSM (derived): RUN (DropCount=0), DRAIN (DropCount>0; fetch continues, stale words discarded).
//   DRAIN->RUN when the last stale rvalid arrives.
// TESTING
//  1 Reset release, RESET_PC=0, gnt=1, 1-cycle mem, InsReady=1 -> ImemAddr 0,4,8..; ProgAddr 0,4,8 consecutive.
//  2 InsReady=0 for 10 cycles -> ImemReq drops after 2 grants; FIFO holds PCs 0,4; no words lost on release.
//  3 Redirect to 0x100 with 2 in flight -> both stale responses dropped; next InsValid has ProgAddr=0x100.
//  4 Redirect BranchAddr=0x202 -> MisalignFault one pulse, fetch from 0x200; BranchAddr=0x201 -> no fault, 0x200.
//  5 RESET_PC=0xFFFFFFFC -> fetch 0xFFFFFFFC then 0x00000000.
//  6 nReset low with 1 in flight -> outputs reset asynchronously; the late rvalid is ignored; fetch restarts at RESET_PC.
//  Random gnt/rvalid latency (1-4) + random redirects -> decoder stream equals golden PC sequence;
//   invariant assertions hold throughout.

Source files
------------

// File: rtl/instruction_fetch.sv
// Fetch stage feeding the RV32I decoder: owns the PC, issues word reads over req/gnt/rvalid,
// buffers returned words with their PCs and discards stale responses after a redirect.
module instruction_fetch #(
    parameter int unsigned      dataW      = 32,
    parameter logic [dataW-1:0] RESET_PC   = '0,
    parameter int unsigned      FIFO_DEPTH = 2
) (
    input  logic             Clock,
    input  logic             nReset,
    output logic             ImemReq,
    output logic [dataW-1:0] ImemAddr,
    input  logic             ImemGnt,
    input  logic             ImemRValid,
    input  logic [dataW-1:0] ImemRData,
    output logic [dataW-1:0] rawIns,
    output logic [dataW-1:0] ProgAddr,
    output logic             InsValid,
    input  logic             InsReady,
    input  logic             Redirect,
    input  logic [dataW-1:0] BranchAddr,
    output logic             MisalignFault
);

    localparam int unsigned PW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW      = PW + 1;
    localparam logic [CW:0] DEPTH_C = (CW + 1)'(FIFO_DEPTH);

    typedef enum logic {
        RUN,
        DRAIN
    } state_t;

    state_t state, state_next;

    logic [dataW-1:0] fetch_pc, fetch_pc_next;
    logic [CW-1:0]    in_flight, in_flight_next;
    logic [CW-1:0]    drop_count, drop_next;
    logic [CW-1:0]    count, count_next;

    logic [dataW-1:0] pcq [FIFO_DEPTH];
    logic [PW-1:0]    pcq_wr, pcq_rd;

    logic [dataW-1:0] buf_pc   [FIFO_DEPTH];
    logic [dataW-1:0] buf_data [FIFO_DEPTH];
    logic [PW-1:0]    buf_wr, buf_rd;

    logic grant, rsp, drop, push, pop;
    logic misalign;
    logic unused_bit;

    // Bit 0 of a jump target is discarded by definition (JALR)
    assign unused_bit = BranchAddr[0];

    assign ImemReq  = nReset && !Redirect &&
                      (({1'b0, in_flight} + {1'b0, count}) < DEPTH_C);
    assign ImemAddr = fetch_pc;

    // A response with nothing outstanding belongs to a transaction killed by reset
    assign grant = ImemReq && ImemGnt;
    assign rsp   = ImemRValid && (in_flight != '0);
    assign drop  = rsp && (state == DRAIN);
    assign push  = rsp && !drop && !Redirect;
    assign pop   = InsValid && InsReady;

    assign in_flight_next = in_flight + CW'(grant) - CW'(rsp);
    assign count_next     = count + CW'(push) - CW'(pop);
    assign fetch_pc_next  = Redirect ? {BranchAddr[dataW-1:2], 2'b00} :
                            grant    ? fetch_pc + dataW'(4) : fetch_pc;

    always_comb begin
        state_next = state;
        drop_next  = drop_count;
        unique case (state)
            RUN: begin
                if (Redirect && (in_flight_next != '0)) begin
                    state_next = DRAIN;
                    drop_next  = in_flight_next;
                end
            end
            DRAIN: begin
                // A redirect recounts everything still outstanding, including words already marked stale
                if (Redirect) begin
                    drop_next  = in_flight_next;
                    state_next = (in_flight_next != '0) ? DRAIN : RUN;
                end else if (drop) begin
                    drop_next = drop_count - CW'(1);
                    if (drop_count == CW'(1)) begin
                        state_next = RUN;
                    end
                end
            end
            default: begin
                state_next = RUN;
                drop_next  = '0;
            end
        endcase
    end

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state      <= RUN;
            drop_count <= '0;
            in_flight  <= '0;
            fetch_pc   <= RESET_PC;
            misalign   <= 1'b0;
        end else begin
            state      <= state_next;
            drop_count <= drop_next;
            in_flight  <= in_flight_next;
            fetch_pc   <= fetch_pc_next;
            misalign   <= Redirect && BranchAddr[1];
        end
    end

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            pcq_wr <= '0;
            pcq_rd <= '0;
        end else begin
            if (grant) begin
                pcq_wr <= pcq_wr + PW'(1);
            end
            if (rsp) begin
                pcq_rd <= pcq_rd + PW'(1);
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (grant) begin
            pcq[pcq_wr] <= fetch_pc;
        end
    end

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            buf_wr <= '0;
            buf_rd <= '0;
            count  <= '0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                buf_pc[i]   <= '0;
                buf_data[i] <= '0;
            end
        end else if (Redirect) begin
            buf_wr <= '0;
            buf_rd <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                buf_pc[buf_wr]   <= pcq[pcq_rd];
                buf_data[buf_wr] <= ImemRData;
                buf_wr           <= buf_wr + PW'(1);
            end
            if (pop) begin
                buf_rd <= buf_rd + PW'(1);
            end
            count <= count_next;
        end
    end

    assign InsValid      = (count != '0);
    assign rawIns        = buf_data[buf_rd];
    assign ProgAddr      = buf_pc[buf_rd];
    assign MisalignFault = misalign;

    a_capacity: assert property (@(posedge Clock) disable iff (!nReset)
        ({1'b0, in_flight} + {1'b0, count}) <= DEPTH_C);
    a_drop_bound: assert property (@(posedge Clock) disable iff (!nReset)
        drop_count <= in_flight);
    a_state_match: assert property (@(posedge Clock) disable iff (!nReset)
        (state == DRAIN) == (drop_count != '0));

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed sequences, a redirect vector table and a randomized run
// compared against a PC-stream reference model with an in-order, variable-latency memory.
`timescale 1ns/1ps
module tb_instruction_fetch;

    localparam logic [31:0] RST_PC = 32'h0;
    localparam int unsigned DEPTH  = 2;

    logic        Clock;
    logic        nReset;
    logic        ImemReq;
    logic [31:0] ImemAddr;
    logic        ImemGnt;
    logic        ImemRValid;
    logic [31:0] ImemRData;
    logic [31:0] rawIns;
    logic [31:0] ProgAddr;
    logic        InsValid;
    logic        InsReady;
    logic        Redirect;
    logic [31:0] BranchAddr;
    logic        MisalignFault;

    logic        rst2, req2, gnt2, rvalid2, valid2, ready2, redir2, fault2;
    logic [31:0] addr2, rdata2, ins2, pc2, baddr2;

    instruction_fetch #(.dataW(32), .RESET_PC(RST_PC), .FIFO_DEPTH(DEPTH)) dut (
        .Clock(Clock), .nReset(nReset),
        .ImemReq(ImemReq), .ImemAddr(ImemAddr), .ImemGnt(ImemGnt),
        .ImemRValid(ImemRValid), .ImemRData(ImemRData),
        .rawIns(rawIns), .ProgAddr(ProgAddr), .InsValid(InsValid), .InsReady(InsReady),
        .Redirect(Redirect), .BranchAddr(BranchAddr), .MisalignFault(MisalignFault)
    );

    instruction_fetch #(.dataW(32), .RESET_PC(32'hFFFF_FFFC), .FIFO_DEPTH(2)) dut_wrap (
        .Clock(Clock), .nReset(rst2),
        .ImemReq(req2), .ImemAddr(addr2), .ImemGnt(gnt2),
        .ImemRValid(rvalid2), .ImemRData(rdata2),
        .rawIns(ins2), .ProgAddr(pc2), .InsValid(valid2), .InsReady(ready2),
        .Redirect(redir2), .BranchAddr(baddr2), .MisalignFault(fault2)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    typedef struct {
        logic [31:0] baddr;
        logic        fault;
        logic [31:0] pc;
    } rvec_t;

    mreq_t       memq[$];
    logic [31:0] grant_log[$];
    rvec_t       vecs[$];

    int          total = 0;
    int          passed = 0;
    int          cyc = 0;
    int          lat_min = 1;
    int          lat_max = 1;
    int          grants = 0;
    int          consumed = 0;
    logic [31:0] exp_pc, exp_fetch, last_cons_pc;
    logic        exp_fault;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // One clock of stimulus; the model expects fetch in PC order from the last redirect target
    task automatic step(input logic gnt, input logic ready, input logic redir, input logic [31:0] baddr);
        int due;
        @(posedge Clock);
        cyc++;
        #1;
        check("misalign_fault", {31'b0, MisalignFault}, {31'b0, exp_fault});
        ImemGnt    = gnt;
        InsReady   = ready;
        Redirect   = redir;
        BranchAddr = baddr;
        if (memq.size() > 0 && memq[0].due <= cyc) begin
            ImemRValid = 1'b1;
            ImemRData  = mem_word(memq[0].addr);
        end else begin
            ImemRValid = 1'b0;
            ImemRData  = '0;
        end
        #1;
        check("imem_addr", ImemAddr, exp_fetch);
        if (redir) check("req_in_redirect", {31'b0, ImemReq}, 32'd0);
        if (memq.size() >= DEPTH) check("req_cap", {31'b0, ImemReq}, 32'd0);
        if (ImemRValid) void'(memq.pop_front());
        if (ImemReq && ImemGnt) begin
            due = cyc + int'($urandom_range(lat_max, lat_min));
            memq.push_back('{ImemAddr, due});
            grant_log.push_back(ImemAddr);
            grants++;
            exp_fetch = exp_fetch + 32'd4;
        end
        if (InsValid && InsReady) begin
            check("stream_pc", ProgAddr, exp_pc);
            check("stream_ins", rawIns, mem_word(exp_pc));
            last_cons_pc = ProgAddr;
            consumed++;
            exp_pc = exp_pc + 32'd4;
        end
        exp_fault = redir && baddr[1];
        if (redir) begin
            exp_pc    = {baddr[31:2], 2'b00};
            exp_fetch = {baddr[31:2], 2'b00};
        end
    endtask

    task automatic do_reset(input bit keep_mem);
        nReset = 1'b0;
        ImemGnt = 1'b0; ImemRValid = 1'b0; ImemRData = '0;
        InsReady = 1'b0; Redirect = 1'b0; BranchAddr = '0;
        if (!keep_mem) memq.delete();
        grant_log.delete();
        exp_pc = RST_PC; exp_fetch = RST_PC; exp_fault = 1'b0;
        grants = 0; consumed = 0;
        repeat (2) @(posedge Clock);
        @(negedge Clock);
        nReset = 1'b1;
    endtask

    initial begin
        vecs.push_back('{32'h0000_0202, 1'b1, 32'h0000_0200});
        vecs.push_back('{32'h0000_0201, 1'b0, 32'h0000_0200});
        vecs.push_back('{32'h0000_0103, 1'b1, 32'h0000_0100});
        vecs.push_back('{32'h0000_0040, 1'b0, 32'h0000_0040});
        vecs.push_back('{32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFC});
        vecs.push_back('{32'h7FFF_FFFD, 1'b0, 32'h7FFF_FFFC});

        rst2 = 1'b0; gnt2 = 1'b0; rvalid2 = 1'b0; rdata2 = '0;
        ready2 = 1'b0; redir2 = 1'b0; baddr2 = '0;
        nReset = 1'b0; ImemGnt = 1'b0; ImemRValid = 1'b0; ImemRData = '0;
        InsReady = 1'b0; Redirect = 1'b0; BranchAddr = '0;

        // Reset state
        #12;
        check("rst_req", {31'b0, ImemReq}, 32'd0);
        check("rst_valid", {31'b0, InsValid}, 32'd0);
        check("rst_fault", {31'b0, MisalignFault}, 32'd0);
        check("rst_rawins", rawIns, 32'd0);
        check("rst_progaddr", ProgAddr, 32'd0);
        check("rst_addr", ImemAddr, RST_PC);

        // Streaming fetch, 1-cycle memory
        do_reset(0);
        lat_min = 1; lat_max = 1;
        repeat (12) step(1'b1, 1'b1, 1'b0, '0);
        check("t1_grants", {31'b0, grant_log.size() >= 4}, 32'd1);
        for (int i = 0; i < 4 && i < grant_log.size(); i++)
            check("t1_fetch_addr", grant_log[i], 32'(4 * i));
        check("t1_consumed", {31'b0, consumed >= 5}, 32'd1);

        // Backpressure: two grants then the request stalls
        do_reset(0);
        repeat (10) step(1'b1, 1'b0, 1'b0, '0);
        check("t2_grants", grants, 32'd2);
        check("t2_req_low", {31'b0, ImemReq}, 32'd0);
        check("t2_valid", {31'b0, InsValid}, 32'd1);
        check("t2_head_pc", ProgAddr, 32'd0);
        repeat (10) step(1'b1, 1'b1, 1'b0, '0);
        check("t2_consumed", {31'b0, consumed >= 4}, 32'd1);

        // Redirect with two words in flight
        do_reset(0);
        lat_min = 4; lat_max = 4;
        repeat (2) step(1'b1, 1'b1, 1'b0, '0);
        step(1'b0, 1'b1, 1'b1, 32'h0000_0100);
        lat_min = 1; lat_max = 1;
        consumed = 0;
        for (int k = 0; k < 20 && consumed == 0; k++) step(1'b1, 1'b1, 1'b0, '0);
        check("t3_seen", {31'b0, consumed > 0}, 32'd1);
        check("t3_first_pc", last_cons_pc, 32'h0000_0100);

        // Redirect target alignment and misalign pulse
        do_reset(0);
        foreach (vecs[v]) begin
            step(1'b0, 1'b1, 1'b1, vecs[v].baddr);
            consumed = 0;
            step(1'b1, 1'b1, 1'b0, '0);
            check("t4_fault", {31'b0, MisalignFault}, {31'b0, vecs[v].fault});
            check("t4_fetch", ImemAddr, vecs[v].pc);
            for (int k = 0; k < 12 && consumed == 0; k++) step(1'b1, 1'b1, 1'b0, '0);
            check("t4_first_pc", last_cons_pc, vecs[v].pc);
        end

        // RESET_PC at the top of the address space wraps to zero
        @(negedge Clock);
        rst2 = 1'b1; gnt2 = 1'b1;
        #1;
        check("t5_addr0", addr2, 32'hFFFF_FFFC);
        check("t5_req0", {31'b0, req2}, 32'd1);
        @(posedge Clock); #1;
        check("t5_addr1", addr2, 32'h0000_0000);
        @(posedge Clock); #1;
        check("t5_req_full", {31'b0, req2}, 32'd0);
        rvalid2 = 1'b1; rdata2 = 32'h0000_0013;
        @(posedge Clock); #1;
        rdata2 = 32'h0000_0093;
        check("t5_valid", {31'b0, valid2}, 32'd1);
        check("t5_pc0", pc2, 32'hFFFF_FFFC);
        check("t5_ins0", ins2, 32'h0000_0013);
        @(posedge Clock); #1;
        rvalid2 = 1'b0; ready2 = 1'b1;
        @(posedge Clock); #1;
        check("t5_pc1", pc2, 32'h0000_0000);
        check("t5_ins1", ins2, 32'h0000_0093);
        ready2 = 1'b0; gnt2 = 1'b0;

        // Asynchronous reset with one word buffered and one in flight
        do_reset(0);
        lat_min = 1; lat_max = 1;
        step(1'b1, 1'b0, 1'b0, '0);
        lat_min = 3; lat_max = 3;
        step(1'b1, 1'b0, 1'b0, '0);
        @(posedge Clock); #1;
        check("t6_pre_valid", {31'b0, InsValid}, 32'd1);
        #2;
        nReset = 1'b0;
        #1;
        check("t6_valid", {31'b0, InsValid}, 32'd0);
        check("t6_req", {31'b0, ImemReq}, 32'd0);
        check("t6_rawins", rawIns, 32'd0);
        check("t6_progaddr", ProgAddr, 32'd0);
        check("t6_addr", ImemAddr, RST_PC);
        do_reset(1);
        for (int k = 0; k < 10 && memq.size() > 0; k++) step(1'b0, 1'b1, 1'b0, '0);
        check("t6_stale_sent", memq.size(), 32'd0);
        step(1'b0, 1'b1, 1'b0, '0);
        check("t6_stale_ignored", {31'b0, InsValid}, 32'd0);
        lat_min = 1; lat_max = 1;
        repeat (10) step(1'b1, 1'b1, 1'b0, '0);
        check("t6_restart", {31'b0, consumed >= 3}, 32'd1);

        // Randomized traffic with redirects
        do_reset(0);
        lat_min = 1; lat_max = 4;
        for (int k = 0; k < 3000; k++) begin
            logic [31:0] tgt;
            tgt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
            step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0, tgt);
        end
        consumed = 0;
        repeat (40) step(1'b1, 1'b1, 1'b0, '0);
        check("rand_liveness", {31'b0, consumed >= 5}, 32'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
